// File: rtl/pspin_pkt_alloc_arb.sv
// Round-robin arbiter funnelling NUM_PORTS packet requesters into the single allocator request port.
// Optional per-port accept / stall counters are built when PSPIN_PKT_ALLOC_ARB_STATS_EN is defined.
module pspin_pkt_alloc_arb #(
   parameter int  NUM_PORTS = 4,
   parameter int  TAG_WIDTH = 32,
   parameter int  LEN_WIDTH = 20,
   localparam int SRC_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS*TAG_WIDTH-1:0] s_pkt_tag_i,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0] s_pkt_len_i,
   input  logic [NUM_PORTS-1:0]           s_pkt_valid_i,
   output logic [NUM_PORTS-1:0]           s_pkt_ready_o,
   output logic [TAG_WIDTH-1:0]           m_pkt_tag_o,
   output logic [LEN_WIDTH-1:0]           m_pkt_len_o,
   output logic [SRC_WIDTH-1:0]           m_pkt_src_o,
   output logic                           m_pkt_valid_o,
   input  logic                           m_pkt_ready_i,
   output logic [NUM_PORTS*32-1:0]        stat_accept_o,
   output logic [31:0]                    stat_stall_o
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e                state_q, state_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [SRC_WIDTH-1:0]  src_q, src_d;
   logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

   logic                  any_valid;
   logic [SRC_WIDTH-1:0]  win_idx;
   logic [SRC_WIDTH-1:0]  cand;
   int                    idx;
   logic                  load_en;
   logic                  grant_en;

   // Scan from the far end back toward rr_ptr so the closest valid port overwrites the rest.
   always_comb begin
      any_valid = 1'b0;
      win_idx   = '0;
      idx       = 0;
      cand      = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         cand = idx[SRC_WIDTH-1:0];
         if (s_pkt_valid_i[cand]) begin
            any_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign load_en  = (state_q == EMPTY) || m_pkt_ready_i;
   assign grant_en = load_en && any_valid && !rst;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign s_pkt_ready_o[gi] = grant_en && (win_idx == SRC_WIDTH'(gi));
   end

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      len_d    = len_q;
      src_d    = src_q;
      rr_ptr_d = rr_ptr_q;
      if (load_en) begin
         if (any_valid) begin
            state_d  = FULL;
            tag_d    = s_pkt_tag_i[win_idx*TAG_WIDTH +: TAG_WIDTH];
            len_d    = s_pkt_len_i[win_idx*LEN_WIDTH +: LEN_WIDTH];
            src_d    = win_idx;
            rr_ptr_d = (win_idx == SRC_WIDTH'(NUM_PORTS - 1)) ? '0 : win_idx + SRC_WIDTH'(1);
         end else begin
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= EMPTY;
         tag_q    <= '0;
         len_q    <= '0;
         src_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         len_q    <= len_d;
         src_q    <= src_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign m_pkt_valid_o = (state_q == FULL);
   assign m_pkt_tag_o   = tag_q;
   assign m_pkt_len_o   = len_q;
   assign m_pkt_src_o   = src_q;

`ifdef PSPIN_PKT_ALLOC_ARB_STATS_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (state_q == FULL && !m_pkt_ready_i) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
   assign stat_stall_o = stall_cnt_q;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
      logic [31:0] acc_cnt_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_cnt_q <= '0;
         end else if (s_pkt_ready_o[gi]) begin
            acc_cnt_q <= acc_cnt_q + 32'd1;
         end
      end
      assign stat_accept_o[gi*32 +: 32] = acc_cnt_q;
   end
`else
   assign stat_accept_o = '0;
   assign stat_stall_o  = '0;
`endif

endmodule

// File: tb/tb_pspin_pkt_alloc_arb.sv
// Scoreboard bench for pspin_pkt_alloc_arb: queue-based round-robin reference model plus output monitor.
module tb_pspin_pkt_alloc_arb;
   localparam int NP = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP*32-1:0]  s_tag;
   logic [NP*20-1:0]  s_len;
   logic [NP-1:0]     s_valid;
   logic [NP-1:0]     s_ready;
   logic [31:0]       m_tag;
   logic [19:0]       m_len;
   logic [1:0]        m_src;
   logic              m_valid;
   logic              m_ready;
   logic [NP*32-1:0]  stat_acc;
   logic [31:0]       stat_stall;

   pspin_pkt_alloc_arb #(.NUM_PORTS(NP), .TAG_WIDTH(32), .LEN_WIDTH(20)) dut (
      .clk(clk), .rst(rst),
      .s_pkt_tag_i(s_tag), .s_pkt_len_i(s_len), .s_pkt_valid_i(s_valid), .s_pkt_ready_o(s_ready),
      .m_pkt_tag_o(m_tag), .m_pkt_len_o(m_len), .m_pkt_src_o(m_src),
      .m_pkt_valid_o(m_valid), .m_pkt_ready_i(m_ready),
      .stat_accept_o(stat_acc), .stat_stall_o(stat_stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] tag;
      logic [19:0] len;
      logic [1:0]  src;
   } exp_t;

   exp_t        sb_q[$];
   bit          req_v[NP];
   logic [31:0] req_tag[NP];
   logic [19:0] req_len[NP];
   bit          full_m;
   int          rr_m;
   int unsigned acc_m[NP];
   int unsigned stall_m;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int p);
      for (int k = 0; k < NP; k++) begin
         if (req_v[(p + k) % NP]) return (p + k) % NP;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [31:0] t, input logic [19:0] l);
      req_v[i]   = 1'b1;
      req_tag[i] = t;
      req_len[i] = l;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NP; i++) req_v[i] = 1'b0;
   endtask

   task automatic step(input bit rdy);
      int          w;
      bit          load;
      logic [NP-1:0] exp_rdy;
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
         s_valid[i]         = req_v[i];
         s_tag[i*32 +: 32]  = req_tag[i];
         s_len[i*20 +: 20]  = req_len[i];
      end
      m_ready = rdy;
      #1;
      w       = pick(rr_m);
      load    = !full_m || rdy;
      exp_rdy = '0;
      if (load && w >= 0) exp_rdy[w] = 1'b1;
      chk("s_pkt_ready", 64'(s_ready), 64'(exp_rdy));
      chk("m_pkt_valid", 64'(m_valid), 64'(full_m));
`ifdef PSPIN_PKT_ALLOC_ARB_STATS_EN
      for (int i = 0; i < NP; i++) chk("stat_accept", 64'(stat_acc[i*32 +: 32]), 64'(acc_m[i]));
      chk("stat_stall", 64'(stat_stall), 64'(stall_m));
`else
      chk("stat_accept_zero", 64'(stat_acc), 64'd0);
      chk("stat_stall_zero", 64'(stat_stall), 64'd0);
`endif
      $display("t=%0t rdy=%0b valid=%b grant=%0d", $time, rdy, s_valid, (load ? w : -1));
      if (load && w >= 0) begin
         sb_q.push_back('{tag: req_tag[w], len: req_len[w], src: 2'(w)});
         req_v[w] = 1'b0;
         acc_m[w]++;
         rr_m = (w + 1) % NP;
      end
      if (full_m && !rdy) stall_m++;
      if (load) full_m = (w >= 0);
      @(posedge clk);
   endtask

   task automatic reset_model();
      sb_q.delete();
      full_m  = 1'b0;
      rr_m    = 0;
      stall_m = 0;
      for (int i = 0; i < NP; i++) acc_m[i] = 0;
      clear_reqs();
   endtask

   task automatic rand_step();
      for (int i = 0; i < NP; i++) begin
         if (!req_v[i] && $urandom_range(0, 99) < 50)
            set_req(i, $urandom(), ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom()));
      end
      step($urandom_range(0, 99) < 70);
   endtask

   // Output monitor: pops the oldest expected entry whenever the allocator takes one.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got src %0d tag %0h, expected none", m_src, m_tag);
            end else begin
               e = sb_q.pop_front();
               chk("out_tag", 64'(m_tag), 64'(e.tag));
               chk("out_len", 64'(m_len), 64'(e.len));
               chk("out_src", 64'(m_src), 64'(e.src));
            end
         end
      end
   end

   initial begin
      reset_model();
      for (int i = 0; i < NP; i++) begin
         req_tag[i] = '0;
         req_len[i] = '0;
      end
      s_tag   = '0;
      s_len   = '0;
      s_valid = '1;
      m_ready = 1'b0;
      rst     = 1'b1;
      #2;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_tag", 64'(m_tag), 64'd0);
      chk("rst_m_len", 64'(m_len), 64'd0);
      chk("rst_m_src", 64'(m_src), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // All four ports requesting continuously: strict 0,1,2,3 rotation.
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NP; i++)
            if (!req_v[i]) set_req(i, 32'hA000_0000 + 32'(k * 16 + i), 20'(k * 4 + i));
         step(1'b1);
         #1 chk("rr_sequence_src", 64'(m_src), 64'(k % NP));
      end
      clear_reqs();
      step(1'b1);

      set_req(2, 32'hCAFE0002, 20'd64);
      step(1'b1);
      #1;
      chk("single_tag", 64'(m_tag), 64'h0000_0000_CAFE_0002);
      chk("single_len", 64'(m_len), 64'd64);
      chk("single_src", 64'(m_src), 64'd2);

      // Pointer now at 3: port 3 beats port 0, then port 0 follows.
      set_req(0, 32'h0000_1000, 20'd0);
      set_req(3, 32'h0000_1003, 20'hFFFFF);
      step(1'b1);
      #1 chk("wrap_src3", 64'(m_src), 64'd3);
      step(1'b1);
      #1 chk("wrap_src0", 64'(m_src), 64'd0);

      set_req(1, 32'h0000_2001, 20'd100);
      set_req(2, 32'h0000_2002, 20'd200);
      for (int k = 0; k < 5; k++) begin
         step(1'b0);
         #1;
         chk("bp_src_stable", 64'(m_src), 64'd0);
         chk("bp_tag_stable", 64'(m_tag), 64'h1000);
         chk("bp_valid_stable", 64'(m_valid), 64'd1);
      end
      step(1'b1);

      for (int k = 0; k < 300; k++) rand_step();

      // Reset pulse between clock edges while an entry is held.
      set_req(1, 32'h0000_3001, 20'd5);
      step(1'b1);
      #3 rst = 1'b1;
      #1;
      chk("arst_m_valid", 64'(m_valid), 64'd0);
      chk("arst_s_ready", 64'(s_ready), 64'd0);
      chk("arst_stat_acc", 64'(stat_acc), 64'd0);
      chk("arst_stat_stall", 64'(stat_stall), 64'd0);
      reset_model();
      s_valid = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 60; k++) rand_step();
      clear_reqs();
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
